// File: rtl/labft_pkg.sv
// Shared types and helpers for the LA fault-tolerance checker: FSM states,
// derived datapath widths and the saturating counter increment.
package labft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_DOT,
        ST_CMP,
        ST_REPORT
    } state_e;

    function automatic int xs_w(input int in_w, input int tile_max);
        return in_w + $clog2(tile_max);
    endfunction

    function automatic int e_w(input int in_w, input int n);
        return in_w + $clog2(n);
    endfunction

    function automatic int cmp_w(input int in_w, input int n, input int tile_max);
        return xs_w(in_w, tile_max) + e_w(in_w, n) + $clog2(n);
    endfunction

    // Increment v, holding at 2^w-1 once reached.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] maxv;
        maxv = (32'd1 << w) - 32'd1;
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/labft_lane_dot.sv
// One checked lane: per-column input sums over a tile and a single
// sequential MAC forming the predicted output checksum.
module labft_lane_dot
    import labft_pkg::*;
#(
    parameter int N     = 4,
    parameter int IN_W  = 8,
    parameter int XS_W  = 12,
    parameter int E_W   = 10,
    parameter int CMP_W = 24,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 x_en,
    input  logic [N*IN_W-1:0]    x_vec,
    input  logic                 mac_en,
    input  logic [IDX_W-1:0]     mac_idx,
    input  logic [E_W-1:0]       e_k,
    output logic [CMP_W-1:0]     pred
);

    logic [XS_W-1:0]  xs_q [N];
    logic [XS_W-1:0]  xs_d [N];
    logic [CMP_W-1:0] pred_q;
    logic [CMP_W-1:0] pred_d;

    // clr and x_en together load the first beat of a new tile
    always_comb begin
        for (int k = 0; k < N; k++) begin
            xs_d[k] = clr ? '0 : xs_q[k];
            if (x_en) begin
                xs_d[k] = xs_d[k] + XS_W'(x_vec[k*IN_W +: IN_W]);
            end
        end
        pred_d = clr ? '0 : pred_q;
        if (mac_en) begin
            pred_d = pred_q + CMP_W'(xs_q[mac_idx]) * CMP_W'(e_k);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                xs_q[k] <= '0;
            end
            pred_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                xs_q[k] <= xs_d[k];
            end
            pred_q <= pred_d;
        end
    end

    assign pred = pred_q;

endmodule

// File: rtl/labft_checker_n.sv
// Checksum-based fault checker for an NxN weight-stationary systolic array.
// Optional syndrome output enabled by defining LABFT_SYNDROME_EN.
module labft_checker_n
    import labft_pkg::*;
#(
    parameter int N        = 4,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 32,
    parameter int LANES    = 4,
    parameter int TILE_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               interrupt,
    input  logic                               w_load,
    input  logic [N*IN_W-1:0]                  e_in,
    input  logic                               x_valid,
    input  logic [LANES*N*IN_W-1:0]            x_in,
    input  logic                               y_valid,
    input  logic [LANES*N*OUT_W-1:0]           y_in,
    input  logic [$clog2(TILE_MAX+1)-1:0]      tile_len,
    input  logic                               cnt_clr,
    input  logic                               err_ready,
    output logic                               err_valid,
    output logic [LANES-1:0]                   err_flags,
    output logic [LANES*CNT_W-1:0]             err_count,
    output logic                               busy,
    output logic                               proto_err
`ifdef LABFT_SYNDROME_EN
    ,
    output logic [LANES*cmp_w(IN_W, N, TILE_MAX)-1:0] syndrome
`endif
);

    localparam int TL_W  = $clog2(TILE_MAX + 1);
    localparam int XS_W  = xs_w(IN_W, TILE_MAX);
    localparam int E_W   = e_w(IN_W, N);
    localparam int CMP_W = cmp_w(IN_W, N, TILE_MAX);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_e            state_q, state_d;
    logic [E_W-1:0]    e_acc_q [N];
    logic [E_W-1:0]    e_acc_d [N];
    logic              w_prev_q, w_prev_d;
    logic [TL_W-1:0]   len_q, len_d;
    logic [TL_W-1:0]   x_cnt_q, x_cnt_d;
    logic [TL_W-1:0]   y_cnt_q, y_cnt_d;
    logic [IDX_W-1:0]  dot_idx_q, dot_idx_d;
    logic [CMP_W-1:0]  ys_q [LANES];
    logic [CMP_W-1:0]  ys_d [LANES];
    logic [CNT_W-1:0]  cnt_q [LANES];
    logic [CNT_W-1:0]  cnt_d [LANES];
    logic [LANES-1:0]  flags_q, flags_d;
    logic              proto_q, proto_d;

    logic              proto_set;
    logic              lane_clr;
    logic              x_acc;
    logic              mac_en;
    logic [CMP_W-1:0]  y_sum [LANES];
    logic [CMP_W-1:0]  pred [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            y_sum[l] = '0;
            for (int k = 0; k < N; k++) begin
                y_sum[l] = y_sum[l] + CMP_W'(y_in[(l*N+k)*OUT_W +: OUT_W]);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        e_acc_d   = e_acc_q;
        w_prev_d  = w_load;
        len_d     = len_q;
        x_cnt_d   = x_cnt_q;
        y_cnt_d   = y_cnt_q;
        dot_idx_d = dot_idx_q;
        ys_d      = ys_q;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        proto_set = 1'b0;
        lane_clr  = 1'b0;
        x_acc     = 1'b0;
        mac_en    = 1'b0;

        // A load burst restarts the weight sums on its first beat
        if (w_load) begin
            if (state_q == ST_IDLE) begin
                for (int k = 0; k < N; k++) begin
                    e_acc_d[k] = (w_prev_q ? e_acc_q[k] : '0) + E_W'(e_in[k*IN_W +: IN_W]);
                end
            end else begin
                proto_set = 1'b1;
            end
        end

        if (cnt_clr) begin
            for (int l = 0; l < LANES; l++) begin
                cnt_d[l] = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (x_valid || y_valid) begin
                    len_d     = (tile_len == '0) ? TL_W'(TILE_MAX) : tile_len;
                    lane_clr  = 1'b1;
                    x_acc     = x_valid;
                    x_cnt_d   = TL_W'(x_valid);
                    y_cnt_d   = TL_W'(y_valid);
                    dot_idx_d = '0;
                    for (int l = 0; l < LANES; l++) begin
                        ys_d[l] = y_valid ? y_sum[l] : '0;
                    end
                    state_d = (x_cnt_d == len_d && y_cnt_d == len_d) ? ST_DOT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (x_valid) begin
                    if (x_cnt_q < len_q) begin
                        x_acc   = 1'b1;
                        x_cnt_d = x_cnt_q + TL_W'(1);
                    end else begin
                        proto_set = 1'b1;
                    end
                end
                if (y_valid) begin
                    if (y_cnt_q < len_q) begin
                        y_cnt_d = y_cnt_q + TL_W'(1);
                        for (int l = 0; l < LANES; l++) begin
                            ys_d[l] = ys_q[l] + y_sum[l];
                        end
                    end else begin
                        proto_set = 1'b1;
                    end
                end
                if (x_cnt_d == len_q && y_cnt_d == len_q) begin
                    state_d   = ST_DOT;
                    dot_idx_d = '0;
                end
            end
            ST_DOT: begin
                mac_en    = 1'b1;
                dot_idx_d = dot_idx_q + IDX_W'(1);
                proto_set = proto_set | x_valid | y_valid;
                if (dot_idx_q == IDX_W'(N - 1)) begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                proto_set = proto_set | x_valid | y_valid;
                for (int l = 0; l < LANES; l++) begin
                    flags_d[l] = (pred[l] != ys_q[l]);
                    if (flags_d[l]) begin
                        cnt_d[l] = cnt_clr ? CNT_W'(1) : CNT_W'(sat_inc(32'(cnt_q[l]), CNT_W));
                    end
                end
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                proto_set = proto_set | x_valid | y_valid;
                if (err_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any tile progress in the same cycle
        if (interrupt) begin
            state_d   = ST_IDLE;
            lane_clr  = 1'b1;
            x_acc     = 1'b0;
            mac_en    = 1'b0;
            x_cnt_d   = '0;
            y_cnt_d   = '0;
            dot_idx_d = '0;
            for (int l = 0; l < LANES; l++) begin
                ys_d[l] = '0;
            end
        end

        proto_d = (cnt_clr ? 1'b0 : proto_q) | proto_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            w_prev_q  <= 1'b0;
            len_q     <= '0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            dot_idx_q <= '0;
            flags_q   <= '0;
            proto_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                e_acc_q[k] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                ys_q[l]  <= '0;
                cnt_q[l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            w_prev_q  <= w_prev_d;
            len_q     <= len_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            dot_idx_q <= dot_idx_d;
            flags_q   <= flags_d;
            proto_q   <= proto_d;
            e_acc_q   <= e_acc_d;
            ys_q      <= ys_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        labft_lane_dot #(
            .N     (N),
            .IN_W  (IN_W),
            .XS_W  (XS_W),
            .E_W   (E_W),
            .CMP_W (CMP_W),
            .IDX_W (IDX_W)
        ) u_dot (
            .clk     (clk),
            .rst     (rst),
            .clr     (lane_clr),
            .x_en    (x_acc),
            .x_vec   (x_in[g*N*IN_W +: N*IN_W]),
            .mac_en  (mac_en),
            .mac_idx (dot_idx_q),
            .e_k     (e_acc_q[dot_idx_q]),
            .pred    (pred[g])
        );
    end

`ifdef LABFT_SYNDROME_EN
    logic [CMP_W-1:0] synd_q [LANES];
    logic [CMP_W-1:0] synd_d [LANES];

    always_comb begin
        synd_d = synd_q;
        if (state_q == ST_CMP) begin
            for (int l = 0; l < LANES; l++) begin
                synd_d[l] = pred[l] - ys_q[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < LANES; l++) begin
                synd_q[l] <= '0;
            end
        end else begin
            synd_q <= synd_d;
        end
    end

    always_comb begin
        syndrome = '0;
        for (int l = 0; l < LANES; l++) begin
            syndrome[l*CMP_W +: CMP_W] = synd_q[l];
        end
    end
`endif

    always_comb begin
        err_count = '0;
        for (int l = 0; l < LANES; l++) begin
            err_count[l*CNT_W +: CNT_W] = cnt_q[l];
        end
    end

    assign err_valid = (state_q == ST_REPORT);
    assign err_flags = flags_q;
    assign busy      = (state_q != ST_IDLE);
    assign proto_err = proto_q;

endmodule

// File: tb/tb_labft_checker_n.sv
// Directed, table-driven bench for labft_checker_n (N=4, 2 lanes, 8-vector tiles, 2-bit counters).
module tb_labft_checker_n;
    import labft_pkg::*;

    localparam int N        = 4;
    localparam int IN_W     = 8;
    localparam int OUT_W    = 32;
    localparam int LANES    = 2;
    localparam int TILE_MAX = 8;
    localparam int CNT_W    = 2;
    localparam int TL_W     = $clog2(TILE_MAX + 1);
    localparam int CMP_W    = cmp_w(IN_W, N, TILE_MAX);

    logic                         clk;
    logic                         rst;
    logic                         interrupt;
    logic                         w_load;
    logic [N*IN_W-1:0]            e_in;
    logic                         x_valid;
    logic [LANES*N*IN_W-1:0]      x_in;
    logic                         y_valid;
    logic [LANES*N*OUT_W-1:0]     y_in;
    logic [TL_W-1:0]              tile_len;
    logic                         cnt_clr;
    logic                         err_ready;
    logic                         err_valid;
    logic [LANES-1:0]             err_flags;
    logic [LANES*CNT_W-1:0]       err_count;
    logic                         busy;
    logic                         proto_err;
`ifdef LABFT_SYNDROME_EN
    logic [LANES*CMP_W-1:0]       syndrome;
`endif

    labft_checker_n #(
        .N        (N),
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .LANES    (LANES),
        .TILE_MAX (TILE_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .interrupt (interrupt),
        .w_load    (w_load),
        .e_in      (e_in),
        .x_valid   (x_valid),
        .x_in      (x_in),
        .y_valid   (y_valid),
        .y_in      (y_in),
        .tile_len  (tile_len),
        .cnt_clr   (cnt_clr),
        .err_ready (err_ready),
        .err_valid (err_valid),
        .err_flags (err_flags),
        .err_count (err_count),
        .busy      (busy),
        .proto_err (proto_err)
`ifdef LABFT_SYNDROME_EN
        ,
        .syndrome  (syndrome)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         len;
        int         x0;
        int         x1;
        int         y0;
        int         y1;
        int         bump;
        logic [1:0] flags;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt [LANES];
    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [IN_W-1:0] v);
        for (int i = 0; i < N; i++) begin
            w_load = 1'b1;
            e_in   = {N{v}};
            tick();
        end
        w_load = 1'b0;
        e_in   = '0;
    endtask

    task automatic set_vectors(input vec_t v, input bit first);
        x_in = '0;
        y_in = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < N; k++) begin
                x_in[(l*N+k)*IN_W +: IN_W]   = IN_W'((l == 0) ? v.x0 : v.x1);
                y_in[(l*N+k)*OUT_W +: OUT_W] = OUT_W'((l == 0) ? v.y0 : v.y1);
            end
        end
        if (first) begin
            y_in[N*OUT_W +: OUT_W] = OUT_W'(v.y1 + v.bump);
        end
    endtask

    task automatic drive_tile(input vec_t v, input string name);
        int n_beats;
        n_beats  = (v.len == 0) ? TILE_MAX : v.len;
        tile_len = TL_W'(v.len);
        for (int i = 0; i < n_beats; i++) begin
            set_vectors(v, i == 0);
            x_valid = 1'b1;
            y_valid = 1'b1;
            tick();
        end
        x_valid = 1'b0;
        y_valid = 1'b0;
        check({name, "_busy"}, busy, 1);
    endtask

    // From 1 ns after the final beat edge, wait for the report; optionally
    // hold cnt_clr high across the CMP cycle.
    task automatic wait_report(input bit clr_at_cmp, input string name);
        int  n;
        bit  got;
        n   = 0;
        got = 0;
        while (!got && n < 20) begin
            if (clr_at_cmp && n == N) cnt_clr = 1'b1;
            tick();
            cnt_clr = 1'b0;
            n++;
            if (err_valid) got = 1;
        end
        check({name, "_latency"}, n, N + 1);
    endtask

    function automatic logic [CMP_W-1:0] exp_syn(input vec_t v, input int l);
        int n_beats;
        int p;
        int y;
        n_beats = (v.len == 0) ? TILE_MAX : v.len;
        p = n_beats * N * 4 * ((l == 0) ? v.x0 : v.x1);
        y = n_beats * N * ((l == 0) ? v.y0 : v.y1) + ((l == 1) ? v.bump : 0);
        return CMP_W'(p - y);
    endfunction

    task automatic check_report(input vec_t v, input bit clr_at_cmp, input string name);
        for (int l = 0; l < LANES; l++) begin
            if (clr_at_cmp) begin
                exp_cnt[l] = v.flags[l] ? 1 : 0;
            end else if (v.flags[l] && exp_cnt[l] < (1 << CNT_W) - 1) begin
                exp_cnt[l]++;
            end
        end
        check({name, "_flags"}, err_flags, v.flags);
        for (int l = 0; l < LANES; l++) begin
            check($sformatf("%s_count%0d", name, l), err_count[l*CNT_W +: CNT_W], exp_cnt[l]);
`ifdef LABFT_SYNDROME_EN
            check($sformatf("%s_syn%0d", name, l), syndrome[l*CMP_W +: CMP_W], exp_syn(v, l));
`endif
        end
    endtask

    task automatic handshake(input string name);
        err_ready = 1'b1;
        tick();
        err_ready = 1'b0;
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_valid"}, err_valid, 0);
    endtask

    task automatic run_tile(input vec_t v, input bit clr_at_cmp, input string name);
        drive_tile(v, name);
        wait_report(clr_at_cmp, name);
        check_report(v, clr_at_cmp, name);
        handshake(name);
    endtask

    initial begin
        vec_t clean;
        vec_t bad;
        vec_t both_bad;

        tbl[0] = '{2, 1, 1, 4, 4, 0, 2'b00};
        tbl[1] = '{2, 1, 1, 4, 4, 1, 2'b10};
        tbl[2] = '{3, 2, 3, 8, 12, 0, 2'b00};
        tbl[3] = '{1, 5, 5, 20, 21, 0, 2'b10};
        tbl[4] = '{2, 3, 0, 13, 0, 0, 2'b01};
        tbl[5] = '{0, 255, 255, 1020, 1020, 0, 2'b00};
        clean    = tbl[0];
        bad      = tbl[1];
        both_bad = '{1, 1, 1, 5, 5, 0, 2'b11};
        for (int l = 0; l < LANES; l++) exp_cnt[l] = 0;

        rst       = 1'b0;
        interrupt = 1'b0;
        w_load    = 1'b0;
        e_in      = '0;
        x_valid   = 1'b0;
        x_in      = '0;
        y_valid   = 1'b0;
        y_in      = '0;
        tile_len  = '0;
        cnt_clr   = 1'b0;
        err_ready = 1'b0;
        repeat (3) tick();
        check("rst_err_valid", err_valid, 0);
        check("rst_err_flags", err_flags, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        check("rst_proto_err", proto_err, 0);
        rst = 1'b1;
        tick();

        // A second burst must restart the sums: 12 from the first, then 4
        load_weights(8'd3);
        tick();
        load_weights(8'd1);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_tile(tbl[i], 1'b0, $sformatf("tbl%0d", i));
        end
        check("tbl_proto_err", proto_err, 0);

        // Abort after one input beat
        tile_len = TL_W'(2);
        set_vectors(clean, 1'b1);
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        check("intr_busy_before", busy, 1);
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        check("intr_busy_after", busy, 0);
        check("intr_valid_after", err_valid, 0);
        repeat (8) tick();
        check("intr_no_report", err_valid, 0);
        run_tile(clean, 1'b0, "post_intr");

        // Backpressure with a stray input beat while reporting
        drive_tile(bad, "bp");
        wait_report(1'b0, "bp");
        for (int c = 0; c < 10; c++) begin
            if (c == 3) x_valid = 1'b1;
            tick();
            x_valid = 1'b0;
            check($sformatf("bp_hold_valid%0d", c), err_valid, 1);
            check($sformatf("bp_hold_flags%0d", c), err_flags, 2'b10);
        end
        check("bp_proto_err", proto_err, 1);
        check_report(bad, 1'b0, "bp");
        handshake("bp");
        run_tile(clean, 1'b0, "post_bp");
        check("post_bp_proto_kept", proto_err, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int l = 0; l < LANES; l++) exp_cnt[l] = 0;
        check("clr_proto_err", proto_err, 0);
        check("clr_err_count", err_count, 0);

        // Saturation, then clear coincident with a CMP increment
        for (int i = 0; i < 4; i++) begin
            run_tile(both_bad, 1'b0, $sformatf("sat%0d", i));
        end
        check("sat_count_max", err_count, {CNT_W'(3), CNT_W'(3)});
        run_tile(both_bad, 1'b1, "sat_clr");
        check("sat_clr_count", err_count, {CNT_W'(1), CNT_W'(1)});

        // Asynchronous reset in the middle of DOT
        drive_tile(clean, "rdot");
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rdot_err_valid", err_valid, 0);
        check("rdot_err_flags", err_flags, 0);
        check("rdot_err_count", err_count, 0);
        check("rdot_busy", busy, 0);
        check("rdot_proto_err", proto_err, 0);
        for (int l = 0; l < LANES; l++) exp_cnt[l] = 0;
        #1;
        rst = 1'b1;
        tick();
        load_weights(8'd1);
        tick();
        run_tile(clean, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
